ap_ddr_arbiter: RTL and testbench
=================================

Name: ap_ddr_arbiter

Overview:
- Downstream neighbour of the data cache. Arbitrates its three DDR requests (DATA_read_req, DATA_store_req, JMP_ADDR_read_req) onto one burst-oriented DDR user interface.
- Returns read beats, beat counts and write-data requests to the cache in the format the cache consumes.
- Publishes its state as state_interface_module. Value 9 (MEM_WRITE_DATA_STORE) gates the cache's store counter.

Parameters:
- DATA_WIDTH, 16, cache word width
- MEM_DATA_WIDTH, 32, DDR user-interface beat width (must be ≥ DDR_ADDR_WIDTH and ≥ DATA_WIDTH)
- DDR_ADDR_WIDTH, 28, DDR address width
- DATA_CACHE_DEPTH, 16, words per cache line
- TIMEOUT_CYCLES, 1024, cycles allowed per burst before error

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- DATA_read_req  in  1  cache line-fill request
- DATA_store_req  in  1  cache line write-back request
- JMP_ADDR_read_req  in  1  jump-address fetch request
- DATA_read_addr  in  DDR_ADDR_WIDTH  fill / jump address
- DATA_write_addr  in  DDR_ADDR_WIDTH  write-back address
- DATA_to_ddr  in  DATA_WIDTH  write-back word from cache
- data_to_ddr_rdy  in  1  DATA_to_ddr valid
- DATA_to_cache  out  DATA_WIDTH  registered read beat
- JMP_ADDR_to_cache  out  DDR_ADDR_WIDTH  registered jump address
- rd_cnt_data  out  10  read beats delivered in current burst
- rd_burst_data_valid  out  1  registered beat-valid
- wr_burst_data_req  out  1  write-beat request to cache
- state_interface_module  out  4  current state code
- arb_err  out  1  sticky timeout flag
- rd_burst_req / wr_burst_req  out  1  DDR burst requests
- rd_burst_len / wr_burst_len  out  10  burst lengths
- rd_burst_addr / wr_burst_addr  out  DDR_ADDR_WIDTH  burst addresses
- rd_burst_data  in  MEM_DATA_WIDTH  DDR read beat
- rd_burst_data_valid_ddr  in  1  DDR read beat valid
- rd_burst_finish / wr_burst_finish  in  1  DDR burst complete pulses
- wr_burst_data_req_ddr  in  1  DDR requests next write beat
- wr_burst_data  out  MEM_DATA_WIDTH  write beat to DDR

Behaviour:
- Reset (async, rst low), all outputs 0: state IDLE, all *_req low, counters 0, arb_err 0. Reset mid-burst drops DDR requests immediately; no completion is owed.
- State codes, driven on state_interface_module:
  - IDLE = 0
  - MEM_READ_DATA = 2
  - MEM_READ_JMP = 3
  - MEM_WRITE_DATA_STORE = 9
  - RELEASE = 10
- Arbitration, sampled in IDLE only: fixed priority DATA_store_req > JMP_ADDR_read_req > DATA_read_req. Non-preemptive. A lower request raised mid-burst waits.
- IDLE → MEM_READ_DATA, registered on entry:
  - rd_burst_req = 1, rd_burst_addr = DATA_read_addr, rd_burst_len = DATA_CACHE_DEPTH + 1 (one guard beat; the cache exits fill on count > depth).
  - rd_burst_req drops the cycle after rd_burst_finish.
- Per read beat (rd_burst_data_valid_ddr = 1 at edge N), at edge N+1:
  - rd_burst_data_valid = 1
  - DATA_to_cache = rd_burst_data[DATA_WIDTH-1:0]
  - rd_cnt_data increments by 1
  - Net: one-cycle latency, and count equals the beat index + 1.
- MEM_READ_JMP: same mechanics with rd_burst_len = 1. JMP_ADDR_to_cache = rd_burst_data[DDR_ADDR_WIDTH-1:0], registered with the beat.
- MEM_WRITE_DATA_STORE:
  - wr_burst_req = 1, wr_burst_addr = DATA_write_addr, wr_burst_len = DATA_CACHE_DEPTH.
  - wr_burst_data_req = wr_burst_data_req_ddr, combinational, gated by state.
  - wr_burst_data = zero-extended DATA_to_ddr, combinational.
  - A DDR beat request while data_to_ddr_rdy = 0 forwards zero and raises arb_err.
- Any burst state → RELEASE on its *_finish pulse.
- RELEASE: holds rd_cnt_data (cache still compares it) until the granted requester deasserts, then → IDLE, clearing rd_cnt_data to 0 on entry to IDLE.
- A request still high one cycle after IDLE entry is treated as a new request.
- Watchdog: a 10-bit-plus counter runs in burst states. When it reaches TIMEOUT_CYCLES: arb_err = 1 (sticky until reset), DDR requests drop, → RELEASE.
- rd_cnt_data saturates at 1023. Extra beats beyond the burst length are counted but never wrap.
- Finish pulse and a new request in the same cycle: finish wins; the request is serviced after RELEASE.

Decomposition:
- Shared package ap_mem_pkg:
  - state codes, including MEM_WRITE_DATA_STORE = 9, also used by the cache
  - requester enum
  - burst-length constants
- One natural sub-module, ap_burst_watchdog: the timeout counter with enable and clear, producing the expiry pulse.

Test Plan:
- DATA_read_req with addr 0x80 → rd_burst_addr 0x80, len 17; 17 beats (values 0..16) → DATA_to_cache 0..16 one cycle late, rd_cnt_data ends at 17 and holds until req drops, state 2 → 10 → 0.
- DATA_store_req with addr 0x400, 16 DDR beat requests, cache supplies 0xA000 + i → wr_burst_data sequence 0xA000..0xA00F, state 9 throughout, then 10 → 0.
- All three requests high in one IDLE cycle → store serviced first, then jump, then fill; state sequence 9, 10, 0, 3, 10, 0, 2.
- JMP_ADDR_read_req, DDR returns 0x0123_4567 → JMP_ADDR_to_cache = 0x0123_4567 with rd_burst_data_valid = 1 and rd_cnt_data = 1 in the same cycle.
- Fill with DDR never finishing (TIMEOUT_CYCLES = 64) → arb_err = 1 at cycle 64, rd_burst_req = 0, → RELEASE.
- rst pulled low mid-write → all outputs 0 asynchronously; a read afterwards works normally.

Source files
------------

// File: rtl/ap_mem_pkg.sv
// Shared definitions between the data cache and its DDR arbiter:
// state codes, requester identities and burst-length helpers.
package ap_mem_pkg;

    // The cache decodes MEM_WRITE_DATA_STORE to gate its store counter.
    typedef enum logic [3:0] {
        IDLE                 = 4'd0,
        MEM_READ_DATA        = 4'd2,
        MEM_READ_JMP         = 4'd3,
        MEM_WRITE_DATA_STORE = 4'd9,
        RELEASE              = 4'd10
    } mem_state_e;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_STORE = 2'd1,
        REQ_JMP   = 2'd2,
        REQ_FILL  = 2'd3
    } requester_e;

    localparam int unsigned BURST_LEN_WIDTH = 10;
    localparam logic [BURST_LEN_WIDTH-1:0] JMP_BURST_LEN = 10'd1;
    localparam logic [BURST_LEN_WIDTH-1:0] RD_CNT_MAX = '1;

    // A fill carries one guard beat: the cache leaves fill once its count exceeds the depth.
    function automatic logic [BURST_LEN_WIDTH-1:0] fill_burst_len(input int unsigned depth);
        return BURST_LEN_WIDTH'(depth + 1);
    endfunction

    function automatic logic [BURST_LEN_WIDTH-1:0] store_burst_len(input int unsigned depth);
        return BURST_LEN_WIDTH'(depth);
    endfunction

endpackage

// File: rtl/ap_burst_watchdog.sv
// Per-burst timeout counter: counts enabled cycles and pulses expire on the
// cycle the count would reach TIMEOUT_CYCLES.
module ap_burst_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] cnt;

    assign expire = en && (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (!expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ap_ddr_arbiter.sv
// Arbitrates the data cache's store, jump-fetch and line-fill requests onto a
// single burst DDR user interface and returns beats in the cache's format.
module ap_ddr_arbiter
    import ap_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned MEM_DATA_WIDTH   = 32,
    parameter int unsigned DDR_ADDR_WIDTH   = 28,
    parameter int unsigned DATA_CACHE_DEPTH = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      DATA_read_req,
    input  logic                      DATA_store_req,
    input  logic                      JMP_ADDR_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
    input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
    input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
    input  logic                      data_to_ddr_rdy,
    output logic [DATA_WIDTH-1:0]     DATA_to_cache,
    output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
    output logic [9:0]                rd_cnt_data,
    output logic                      rd_burst_data_valid,
    output logic                      wr_burst_data_req,
    output logic [3:0]                state_interface_module,
    output logic                      arb_err,
    output logic                      rd_burst_req,
    output logic                      wr_burst_req,
    output logic [9:0]                rd_burst_len,
    output logic [9:0]                wr_burst_len,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic [MEM_DATA_WIDTH-1:0] rd_burst_data,
    input  logic                      rd_burst_data_valid_ddr,
    input  logic                      rd_burst_finish,
    input  logic                      wr_burst_finish,
    input  logic                      wr_burst_data_req_ddr,
    output logic [MEM_DATA_WIDTH-1:0] wr_burst_data
);

    mem_state_e state, state_nxt;
    requester_e grant, grant_nxt;
    logic       in_read, in_write, expire, granted_active;
    logic       unused_rd_hi;

    assign in_read  = (state == MEM_READ_DATA) || (state == MEM_READ_JMP);
    assign in_write = (state == MEM_WRITE_DATA_STORE);
    assign state_interface_module = state;
    assign unused_rd_hi = ^{1'b0, rd_burst_data};

    ap_burst_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (in_read || in_write),
        .clr    (state == IDLE),
        .expire (expire)
    );

    always_comb begin
        granted_active = 1'b0;
        case (grant)
            REQ_STORE: granted_active = DATA_store_req;
            REQ_JMP:   granted_active = JMP_ADDR_read_req;
            REQ_FILL:  granted_active = DATA_read_req;
            default:   granted_active = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (DATA_store_req) begin
                    state_nxt = MEM_WRITE_DATA_STORE;
                    grant_nxt = REQ_STORE;
                end else if (JMP_ADDR_read_req) begin
                    state_nxt = MEM_READ_JMP;
                    grant_nxt = REQ_JMP;
                end else if (DATA_read_req) begin
                    state_nxt = MEM_READ_DATA;
                    grant_nxt = REQ_FILL;
                end
            end
            MEM_READ_DATA, MEM_READ_JMP: begin
                if (rd_burst_finish || expire) state_nxt = RELEASE;
            end
            MEM_WRITE_DATA_STORE: begin
                if (wr_burst_finish || expire) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!granted_active) begin
                    state_nxt = IDLE;
                    grant_nxt = REQ_NONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = REQ_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= REQ_NONE;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Burst requests follow the next state, so they drop on the edge that sees finish or expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_burst_req        <= 1'b0;
            wr_burst_req        <= 1'b0;
            rd_burst_len        <= '0;
            wr_burst_len        <= '0;
            rd_burst_addr       <= '0;
            wr_burst_addr       <= '0;
            rd_burst_data_valid <= 1'b0;
            DATA_to_cache       <= '0;
            JMP_ADDR_to_cache   <= '0;
            rd_cnt_data         <= '0;
            arb_err             <= 1'b0;
        end else begin
            rd_burst_req        <= (state_nxt == MEM_READ_DATA) || (state_nxt == MEM_READ_JMP);
            wr_burst_req        <= (state_nxt == MEM_WRITE_DATA_STORE);
            rd_burst_data_valid <= in_read && rd_burst_data_valid_ddr;

            if (state == IDLE) begin
                if (state_nxt == MEM_READ_DATA) begin
                    rd_burst_addr <= DATA_read_addr;
                    rd_burst_len  <= fill_burst_len(DATA_CACHE_DEPTH);
                end else if (state_nxt == MEM_READ_JMP) begin
                    rd_burst_addr <= DATA_read_addr;
                    rd_burst_len  <= JMP_BURST_LEN;
                end else if (state_nxt == MEM_WRITE_DATA_STORE) begin
                    wr_burst_addr <= DATA_write_addr;
                    wr_burst_len  <= store_burst_len(DATA_CACHE_DEPTH);
                end
            end

            if (in_read && rd_burst_data_valid_ddr) begin
                DATA_to_cache <= rd_burst_data[DATA_WIDTH-1:0];
                if (state == MEM_READ_JMP) JMP_ADDR_to_cache <= rd_burst_data[DDR_ADDR_WIDTH-1:0];
                if (rd_cnt_data != RD_CNT_MAX) rd_cnt_data <= rd_cnt_data + 1'b1;
            end else if (state == RELEASE && state_nxt == IDLE) begin
                rd_cnt_data <= '0;
            end

            if (expire || (in_write && wr_burst_data_req_ddr && !data_to_ddr_rdy)) arb_err <= 1'b1;
        end
    end

    assign wr_burst_data_req = in_write && wr_burst_data_req_ddr;
    assign wr_burst_data     = (in_write && data_to_ddr_rdy) ? MEM_DATA_WIDTH'(DATA_to_ddr) : '0;

endmodule

// File: tb/tb_ap_ddr_arbiter.sv
// Directed bench for ap_ddr_arbiter: fill, store, jump, priority, timeout and
// asynchronous reset, with read/write data checked through an expected queue.
module tb_ap_ddr_arbiter;

    localparam int DW    = 16;
    localparam int MW    = 32;
    localparam int AW    = 28;
    localparam int DEPTH = 16;
    localparam int TO    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          DATA_read_req, DATA_store_req, JMP_ADDR_read_req;
    logic [AW-1:0] DATA_read_addr, DATA_write_addr;
    logic [DW-1:0] DATA_to_ddr;
    logic          data_to_ddr_rdy;
    logic [DW-1:0] DATA_to_cache;
    logic [AW-1:0] JMP_ADDR_to_cache;
    logic [9:0]    rd_cnt_data;
    logic          rd_burst_data_valid, wr_burst_data_req;
    logic [3:0]    state_interface_module;
    logic          arb_err, rd_burst_req, wr_burst_req;
    logic [9:0]    rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic [MW-1:0] rd_burst_data;
    logic          rd_burst_data_valid_ddr, rd_burst_finish, wr_burst_finish, wr_burst_data_req_ddr;
    logic [MW-1:0] wr_burst_data;

    int            checks = 0;
    int            errors = 0;
    logic [MW-1:0] exp_q[$];
    logic [MW-1:0] exp_v;
    int            n;

    ap_ddr_arbiter #(
        .DATA_WIDTH(DW), .MEM_DATA_WIDTH(MW), .DDR_ADDR_WIDTH(AW),
        .DATA_CACHE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .DATA_read_req(DATA_read_req), .DATA_store_req(DATA_store_req),
        .JMP_ADDR_read_req(JMP_ADDR_read_req),
        .DATA_read_addr(DATA_read_addr), .DATA_write_addr(DATA_write_addr),
        .DATA_to_ddr(DATA_to_ddr), .data_to_ddr_rdy(data_to_ddr_rdy),
        .DATA_to_cache(DATA_to_cache), .JMP_ADDR_to_cache(JMP_ADDR_to_cache),
        .rd_cnt_data(rd_cnt_data), .rd_burst_data_valid(rd_burst_data_valid),
        .wr_burst_data_req(wr_burst_data_req), .state_interface_module(state_interface_module),
        .arb_err(arb_err), .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .rd_burst_data(rd_burst_data), .rd_burst_data_valid_ddr(rd_burst_data_valid_ddr),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
        .wr_burst_data_req_ddr(wr_burst_data_req_ddr), .wr_burst_data(wr_burst_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        DATA_read_req = 0; DATA_store_req = 0; JMP_ADDR_read_req = 0;
        DATA_read_addr = '0; DATA_write_addr = '0; DATA_to_ddr = '0; data_to_ddr_rdy = 0;
        rd_burst_data = '0; rd_burst_data_valid_ddr = 0; rd_burst_finish = 0;
        wr_burst_finish = 0; wr_burst_data_req_ddr = 0;
        tick(); tick();
        check("rst_state", state_interface_module, 0);
        check("rst_rd_req", rd_burst_req, 0);
        check("rst_wr_req", wr_burst_req, 0);
        check("rst_cnt", rd_cnt_data, 0);
        check("rst_err", arb_err, 0);
        check("rst_rd_len", rd_burst_len, 0);
        rst = 1'b1;
        tick();

        // Line fill at 0x80: 17 beats, one-cycle latency, count = index + 1.
        DATA_read_req = 1; DATA_read_addr = AW'('h80);
        tick();
        check("fill_state", state_interface_module, 2);
        check("fill_req", rd_burst_req, 1);
        check("fill_addr", rd_burst_addr, 'h80);
        check("fill_len", rd_burst_len, 17);
        for (int i = 0; i <= DEPTH; i++) begin
            rd_burst_data_valid_ddr = 1; rd_burst_data = MW'(i);
            exp_q.push_back(MW'(i));
            tick();
            check("fill_valid", rd_burst_data_valid, 1);
            exp_v = exp_q.pop_front();
            check("fill_data", DATA_to_cache, exp_v);
            check("fill_cnt", rd_cnt_data, MW'(i + 1));
        end
        rd_burst_data_valid_ddr = 0; rd_burst_finish = 1;
        tick();
        check("fill_release", state_interface_module, 10);
        check("fill_req_drop", rd_burst_req, 0);
        check("fill_valid_drop", rd_burst_data_valid, 0);
        rd_burst_finish = 0;
        tick();
        check("fill_hold_state", state_interface_module, 10);
        check("fill_hold_cnt", rd_cnt_data, 17);
        DATA_read_req = 0;
        tick();
        check("fill_idle", state_interface_module, 0);
        check("fill_cnt_clear", rd_cnt_data, 0);

        // Write-back at 0x400: 16 beats forwarded combinationally.
        DATA_store_req = 1; DATA_write_addr = AW'('h400);
        tick();
        check("st_state", state_interface_module, 9);
        check("st_req", wr_burst_req, 1);
        check("st_addr", wr_burst_addr, 'h400);
        check("st_len", wr_burst_len, 16);
        for (int i = 0; i < DEPTH; i++) begin
            wr_burst_data_req_ddr = 1; data_to_ddr_rdy = 1; DATA_to_ddr = DW'('hA000 + i);
            exp_q.push_back(MW'('hA000 + i));
            #1;
            exp_v = exp_q.pop_front();
            check("st_data", wr_burst_data, exp_v);
            check("st_data_req", wr_burst_data_req, 1);
            check("st_state_hold", state_interface_module, 9);
            tick();
        end
        wr_burst_data_req_ddr = 0; data_to_ddr_rdy = 0; wr_burst_finish = 1;
        tick();
        check("st_release", state_interface_module, 10);
        check("st_req_drop", wr_burst_req, 0);
        wr_burst_finish = 0; DATA_store_req = 0;
        tick();
        check("st_idle", state_interface_module, 0);
        check("st_err_clean", arb_err, 0);

        // Asynchronous reset in the middle of a store burst.
        DATA_store_req = 1; DATA_write_addr = AW'('h500);
        tick();
        check("rw_state", state_interface_module, 9);
        wr_burst_data_req_ddr = 1; data_to_ddr_rdy = 1; DATA_to_ddr = DW'('h1234);
        #2;
        rst = 1'b0;
        #1;
        check("rw_state0", state_interface_module, 0);
        check("rw_wr_req0", wr_burst_req, 0);
        check("rw_data0", wr_burst_data, 0);
        check("rw_data_req0", wr_burst_data_req, 0);
        check("rw_len0", wr_burst_len, 0);
        DATA_store_req = 0; wr_burst_data_req_ddr = 0; data_to_ddr_rdy = 0; DATA_to_ddr = '0;
        tick();
        rst = 1'b1;
        tick();

        // Jump fetch after reset: single beat returns the address.
        JMP_ADDR_read_req = 1; DATA_read_addr = AW'('h40);
        tick();
        check("jmp_state", state_interface_module, 3);
        check("jmp_len", rd_burst_len, 1);
        check("jmp_addr", rd_burst_addr, 'h40);
        rd_burst_data_valid_ddr = 1; rd_burst_data = 32'h0123_4567;
        exp_q.push_back(32'h0123_4567);
        tick();
        exp_v = exp_q.pop_front();
        check("jmp_target", JMP_ADDR_to_cache, exp_v);
        check("jmp_valid", rd_burst_data_valid, 1);
        check("jmp_cnt", rd_cnt_data, 1);
        rd_burst_data_valid_ddr = 0; rd_burst_finish = 1;
        tick();
        check("jmp_release", state_interface_module, 10);
        rd_burst_finish = 0; JMP_ADDR_read_req = 0;
        tick();
        check("jmp_idle", state_interface_module, 0);

        // All three requests at once: store, then jump, then fill.
        DATA_store_req = 1; JMP_ADDR_read_req = 1; DATA_read_req = 1;
        tick();
        check("pri_store", state_interface_module, 9);
        wr_burst_finish = 1;
        tick();
        check("pri_rel1", state_interface_module, 10);
        wr_burst_finish = 0; DATA_store_req = 0;
        tick();
        check("pri_idle1", state_interface_module, 0);
        tick();
        check("pri_jmp", state_interface_module, 3);
        rd_burst_finish = 1;
        tick();
        check("pri_rel2", state_interface_module, 10);
        rd_burst_finish = 0; JMP_ADDR_read_req = 0;
        tick();
        check("pri_idle2", state_interface_module, 0);
        tick();
        check("pri_fill", state_interface_module, 2);
        rd_burst_finish = 1;
        tick();
        rd_burst_finish = 0; DATA_read_req = 0;
        tick();
        check("pri_idle3", state_interface_module, 0);

        // Fill that never finishes trips the watchdog after TO burst cycles.
        DATA_read_req = 1; DATA_read_addr = AW'('h200);
        tick();
        check("to_state", state_interface_module, 2);
        n = 0;
        while (arb_err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("to_cycles", MW'(n), MW'(TO));
        check("to_release", state_interface_module, 10);
        check("to_req_drop", rd_burst_req, 0);
        DATA_read_req = 0;
        tick();
        check("to_idle", state_interface_module, 0);
        check("to_err_sticky", arb_err, 1);

        // Store beat requested while the cache has no data: zero forwarded, error raised.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        DATA_store_req = 1;
        tick();
        check("nordy_err_clear", arb_err, 0);
        wr_burst_data_req_ddr = 1; data_to_ddr_rdy = 0; DATA_to_ddr = DW'('hBEEF);
        #1;
        check("nordy_zero", wr_burst_data, 0);
        tick();
        check("nordy_err", arb_err, 1);
        wr_burst_data_req_ddr = 0; DATA_store_req = 0;

        check("queue_empty", MW'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
